// File: rtl/scroll_char_feeder_if.sv
// scroll_char_feeder_if: control, buffer-write and character-stream signals of the scroll feeder
interface scroll_char_feeder_if;
    logic       start;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [6:0] wr_data;
    logic [4:0] msg_len;
    logic       out_ready;
    logic       out_valid;
    logic [6:0] out_seg;
    logic       out_last;
    logic       busy;
    logic       done;

    modport master (
        output start, wr_en, wr_addr, wr_data, msg_len, out_ready,
        input  out_valid, out_seg, out_last, busy, done
    );

    modport slave (
        input  start, wr_en, wr_addr, wr_data, msg_len, out_ready,
        output out_valid, out_seg, out_last, busy, done
    );
endinterface

// File: rtl/scroll_char_feeder.sv
// scroll_char_feeder: streams a stored 7-segment message plus blank padding, one character per tick
module scroll_char_feeder #(
    parameter int TICK_DIV = 25000000,
    parameter int PAD_LEN  = 6
) (
    input logic CLOCK_50,
    input logic RESET_N,
    scroll_char_feeder_if.slave bus
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int IW = $clog2(16 + PAD_LEN + 1);
    localparam logic [6:0] BLANK = 7'h7f;

    typedef enum logic [1:0] {IDLE, WAIT_TICK, PRESENT, FINISH} state_t;

    state_t        state;
    logic [6:0]    mem [16];
    logic [4:0]    len;
    logic [IW-1:0] index;
    logic [CW-1:0] cnt;
    logic [IW-1:0] last_idx;
    logic [6:0]    cur_seg;

    assign last_idx = IW'(len) + IW'(PAD_LEN - 1);
    // A write landing on the same edge the character is captured must still be seen
    assign cur_seg  = (index < IW'(len))
                    ? ((bus.wr_en && IW'(bus.wr_addr) == index) ? bus.wr_data : mem[index[3:0]])
                    : BLANK;

    // Message buffer: writable in every state, cleared to blanks by reset
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 16; i++) mem[i] <= BLANK;
        end else if (bus.wr_en) begin
            mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Sequencer: tick wait, present-and-hold until accepted, one-cycle finish pulse
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= IDLE;
            len           <= '0;
            index         <= '0;
            cnt           <= '0;
            bus.out_valid <= 1'b0;
            bus.out_seg   <= BLANK;
            bus.out_last  <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start && bus.msg_len != 5'd0) begin
                        len      <= (bus.msg_len > 5'd16) ? 5'd16 : bus.msg_len;
                        index    <= '0;
                        cnt      <= CW'(TICK_DIV - 1);
                        bus.busy <= 1'b1;
                        state    <= WAIT_TICK;
                    end
                end
                WAIT_TICK: begin
                    if (cnt == '0) begin
                        bus.out_valid <= 1'b1;
                        bus.out_seg   <= cur_seg;
                        bus.out_last  <= (index == last_idx);
                        state         <= PRESENT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PRESENT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.out_seg   <= BLANK;
                        bus.out_last  <= 1'b0;
                        if (bus.out_last) begin
                            bus.done <= 1'b1;
                            state    <= FINISH;
                        end else begin
                            index <= index + 1'b1;
                            cnt   <= CW'(TICK_DIV - 1);
                            state <= WAIT_TICK;
                        end
                    end
                end
                FINISH: begin
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scroll_char_feeder.sv
// tb_scroll_char_feeder: cycle model comparison plus literal checks of the scrolled character stream
module tb_scroll_char_feeder;
    localparam int TICK_DIV = 2;
    localparam int PAD_LEN  = 6;
    localparam logic [6:0] BL = 7'h7f;
    localparam logic [6:0] SC = 7'b1000110, SP = 7'b0001100, SE = 7'b0000110, SN = 7'b1001000;
    localparam logic [6:0] SB = 7'b0000011, SY = 7'b0010001, SD = 7'b0100001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    scroll_char_feeder_if bus ();

    scroll_char_feeder #(.TICK_DIV(TICK_DIV), .PAD_LEN(PAD_LEN)) dut (
        .CLOCK_50(clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Behavioural model: counts down cycles to each presentation, tracks beat number and buffer contents
    logic       m_busy, m_valid, m_done, m_last;
    logic [6:0] m_seg;
    int         m_beat, m_len, m_wait;
    logic [6:0] m_buf [16];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_valid <= 0; m_done <= 0; m_last <= 0; m_seg <= BL;
            m_beat <= 0; m_len <= 0; m_wait <= 0;
            for (int i = 0; i < 16; i++) m_buf[i] <= BL;
        end else begin
            if (bus.wr_en) m_buf[bus.wr_addr] <= bus.wr_data;
            m_done <= 0;
            if (m_done) m_busy <= 0;
            else if (!m_busy) begin
                if (bus.start && bus.msg_len != 0) begin
                    m_busy <= 1;
                    m_len  <= (bus.msg_len > 16) ? 16 : int'(bus.msg_len);
                    m_beat <= 0;
                    m_wait <= TICK_DIV;
                end
            end else if (m_valid) begin
                if (bus.out_ready) begin
                    m_valid <= 0; m_seg <= BL; m_last <= 0;
                    if (m_beat == m_len + PAD_LEN - 1) m_done <= 1;
                    else begin
                        m_beat <= m_beat + 1;
                        m_wait <= TICK_DIV;
                    end
                end
            end else if (m_wait == 1) begin
                m_valid <= 1;
                m_seg   <= (m_beat < m_len)
                         ? ((bus.wr_en && int'(bus.wr_addr) == m_beat) ? bus.wr_data : m_buf[m_beat])
                         : BL;
                m_last  <= (m_beat == m_len + PAD_LEN - 1);
            end else m_wait <= m_wait - 1;
        end
    end

    // Every cycle out of reset: DUT outputs against the model
    always @(posedge clk) begin
        #1;
        if (rst_n) begin
            chk("out_valid", bus.out_valid, m_valid);
            chk("out_seg", bus.out_seg, m_seg);
            chk("out_last", bus.out_last, m_last);
            chk("busy", bus.busy, m_busy);
            chk("done", bus.done, m_done);
        end
    end

    // Transaction log taken mid-cycle, when inputs and outputs are both settled
    logic [6:0] beats [$];
    logic       lasts [$];
    int         beat_cyc [$];
    int         done_cnt = 0, done_cyc = 0, start_cyc = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                beats.push_back(bus.out_seg);
                lasts.push_back(bus.out_last);
                beat_cyc.push_back(cyc);
            end
            if (bus.done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (bus.start && !bus.busy && bus.msg_len != 0) start_cyc = cyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input int a, input logic [6:0] d);
        bus.wr_en = 1; bus.wr_addr = 4'(a); bus.wr_data = d;
        step();
        bus.wr_en = 0;
    endtask

    task automatic go(input int l);
        bus.start = 1; bus.msg_len = 5'(l);
        step();
        bus.start = 0; bus.msg_len = 0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin
            step();
            n++;
        end
        chk("done_seen", int'(done_cnt != d0), 1);
        step();
        step();
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!bus.out_valid && n < budget) begin
            step();
            n++;
        end
        chk("valid_seen", bus.out_valid, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, bus.out_valid, 0);
        chk({tag, "_seg"}, bus.out_seg, BL);
        chk({tag, "_last"}, bus.out_last, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
    endtask

    // Checks a finished sequence in the log starting at b0 against literal expectations
    task automatic chk_stream(input string tag, input int b0, input int n, input logic [6:0] exp [22]);
        chk({tag, "_beats"}, beats.size() - b0, n);
        if (beats.size() - b0 == n) begin
            for (int i = 0; i < n; i++) begin
                chk({tag, "_seg"}, beats[b0 + i], exp[i]);
                chk({tag, "_last"}, lasts[b0 + i], int'(i == n - 1));
            end
        end
    endtask

    initial begin
        logic [6:0] exp [22];
        int b0, d0;
        bus.start = 0; bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.msg_len = 0; bus.out_ready = 0;
        repeat (3) step();
        chk_reset_outputs("reset");
        rst_n = 1;
        step(); step();
        chk("idle_busy", bus.busy, 0);

        // CPEN with constant ready
        wr(0, SC); wr(1, SP); wr(2, SE); wr(3, SN);
        bus.out_ready = 1;
        b0 = beats.size(); d0 = done_cnt;
        go(4);
        wait_done(d0, 100);
        for (int i = 0; i < 22; i++) exp[i] = BL;
        exp[0] = SC; exp[1] = SP; exp[2] = SE; exp[3] = SN;
        chk_stream("cpen", b0, 10, exp);
        if (beats.size() - b0 == 10) begin
            chk("cpen_first_latency", beat_cyc[b0] - start_cyc, 3);
            for (int i = 1; i < 10; i++) chk("cpen_spacing", beat_cyc[b0 + i] - beat_cyc[b0 + i - 1], 3);
            chk("cpen_done_delay", done_cyc - beat_cyc[b0 + 9], 1);
        end
        chk("cpen_done_count", done_cnt - d0, 1);

        // bye with a 5-cycle stall on beat 1, writes and an ignored start during the stall
        wr(0, SB); wr(1, SY); wr(2, SE);
        bus.out_ready = 0;
        b0 = beats.size(); d0 = done_cnt;
        go(3);
        wait_valid(20);
        for (int k = 0; k < 5; k++) begin
            chk("stall_seg", bus.out_seg, SB);
            chk("stall_valid", bus.out_valid, 1);
            bus.wr_en   = (k == 1) || (k == 2);
            bus.wr_addr = (k == 1) ? 4'd2 : 4'd0;
            bus.wr_data = (k == 1) ? SD : 7'h00;
            bus.start   = (k == 3);
            bus.msg_len = (k == 3) ? 5'd5 : 5'd0;
            step();
        end
        bus.wr_en = 0; bus.start = 0; bus.msg_len = 0;
        bus.out_ready = 1;
        wait_done(d0, 100);
        for (int i = 0; i < 22; i++) exp[i] = BL;
        exp[0] = SB; exp[1] = SY; exp[2] = SD;
        chk_stream("bye", b0, 9, exp);
        chk("bye_done_count", done_cnt - d0, 1);

        // start with zero length is ignored
        bus.start = 1; bus.msg_len = 0;
        step();
        bus.start = 0;
        step();
        chk("zero_len_busy", bus.busy, 0);
        step();

        // asynchronous reset in the middle of a presented beat, then immediate restart
        bus.out_ready = 0;
        go(4);
        wait_valid(20);
        step();
        #1 rst_n = 0;
        #1 chk_reset_outputs("async_reset");
        d0 = done_cnt;
        step(); step();
        rst_n = 1;
        bus.out_ready = 1;
        b0 = beats.size();
        bus.start = 1; bus.msg_len = 3;
        step();
        bus.start = 0; bus.msg_len = 0;
        chk("restart_busy", bus.busy, 1);
        wait_done(d0, 100);
        for (int i = 0; i < 22; i++) exp[i] = BL;
        chk_stream("restart", b0, 9, exp);
        chk("restart_done_count", done_cnt - d0, 1);
        if (beats.size() - b0 == 9) chk("restart_first_latency", beat_cyc[b0] - start_cyc, 3);

        // oversize length is clamped to 16 entries plus padding
        for (int i = 0; i < 16; i++) wr(i, 7'((i * 9 + 1) & 7'h7f));
        b0 = beats.size(); d0 = done_cnt;
        go(20);
        wait_done(d0, 200);
        for (int i = 0; i < 22; i++) exp[i] = (i < 16) ? 7'((i * 9 + 1) & 7'h7f) : BL;
        chk_stream("len20", b0, 22, exp);
        chk("len20_done_count", done_cnt - d0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end
endmodule
